// File: rtl/ccff_ctrl_pkg.sv
// Shared types and helpers for the configuration-chain controller.
package ccff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_e;

  localparam logic MODE_PROGRAM = 1'b0;
  localparam logic MODE_VERIFY  = 1'b1;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one host word and presents it bit by bit, LSB first, with the reload handshake.
module ccff_word_serializer
  import ccff_ctrl_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_i,
  input  logic              shift_i,
  input  logic              final_i,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              ready_o,
  output logic              accept_o,
  output logic              bit_o,
  output logic              last_bit_o
);

  localparam int IdxW = cnt_width(WORD_W);

  logic [WORD_W-1:0] wordBuf_q;
  logic [IdxW-1:0]   bitIdx_q;

  // Ready while waiting for a word, or on the last bit of a word when the chain still needs more.
  assign last_bit_o = (bitIdx_q == IdxW'(WORD_W - 1));
  assign ready_o    = fetch_i | (shift_i & last_bit_o & ~final_i);
  assign accept_o   = ready_o & valid_i;
  assign bit_o      = wordBuf_q[bitIdx_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wordBuf_q <= '0;
      bitIdx_q  <= '0;
    end else if (accept_o) begin
      wordBuf_q <= word_i;
      bitIdx_q  <= '0;
    end else if (shift_i) begin
      bitIdx_q <= bitIdx_q + 1'b1;
    end
  end

endmodule

// File: rtl/ccff_chain_controller.sv
// Streams host words onto a configuration chain and, in verify mode, checks what falls out of the tail.
module ccff_chain_controller
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic                           prog_clk,
  input  logic                           pReset,
  input  logic                           start,
  input  logic                           verify,
  input  logic [WORD_W-1:0]              din,
  input  logic                           din_valid,
  output logic                           din_ready,
  output logic                           ccff_head,
  output logic                           prog_clk_en,
  input  logic                           ccff_tail,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(CHAIN_LEN+1)-1:0] err_count
);

  localparam int CntW = cnt_width(CHAIN_LEN);
  localparam int ErrW = $clog2(CHAIN_LEN + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] bitCnt_q, bitCnt_d;
  logic            verify_q, verify_d;
  logic            err_q, err_d;
  logic [ErrW-1:0] errCount_q, errCount_d;

  logic inShift, inFetch, finalBit, mismatch;
  logic wordAccept, serialBit, lastBit;

  assign inShift  = (state_q == SHIFT);
  assign inFetch  = (state_q == FETCH);
  assign finalBit = inShift && (bitCnt_q == CntW'(CHAIN_LEN - 1));

  ccff_word_serializer #(
    .WORD_W(WORD_W)
  ) u_serializer (
    .clk_i      (prog_clk),
    .rst_i      (pReset),
    .fetch_i    (inFetch),
    .shift_i    (inShift),
    .final_i    (finalBit),
    .valid_i    (din_valid),
    .word_i     (din),
    .ready_o    (din_ready),
    .accept_o   (wordAccept),
    .bit_o      (serialBit),
    .last_bit_o (lastBit)
  );

  // Head is forced low outside SHIFT so the pin is quiet whenever the chain is not clocked.
  assign ccff_head   = inShift & serialBit;
  assign prog_clk_en = inShift;
  assign busy        = inFetch | inShift;
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign err_count   = errCount_q;
  assign mismatch    = inShift && (verify_q == MODE_VERIFY) && (ccff_tail != ccff_head);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      verify_q   <= MODE_PROGRAM;
      err_q      <= 1'b0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      verify_q   <= verify_d;
      err_q      <= err_d;
      errCount_q <= errCount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    verify_d   = verify_q;
    err_d      = err_q;
    errCount_d = errCount_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FETCH;
          bitCnt_d   = '0;
          verify_d   = verify;
          err_d      = 1'b0;
          errCount_d = '0;
        end
      end
      FETCH: begin
        if (wordAccept) state_d = SHIFT;
      end
      SHIFT: begin
        bitCnt_d = bitCnt_q + 1'b1;
        if (mismatch) begin
          err_d = 1'b1;
          if (errCount_q != ErrW'(CHAIN_LEN)) errCount_d = errCount_q + 1'b1;
        end
        // A missing word on the last bit drops back to FETCH so the chain is never clocked on a stall.
        if (finalBit) state_d = DONE;
        else if (lastBit && !wordAccept) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ccff_chain_controller.md
# ccff_chain_controller

Sequences the configuration-chain shift of a string of fle tiles. Accepts a configuration bitstream as WORD_W-bit words over a valid/ready port and serializes it LSB-first onto the chain's ccff_head, gating one shift per bit via prog_clk_en. In VERIFY mode it re-shifts the same stream and compares each bit leaving ccff_tail against the bit entering, so a second pass proves the first. Sits between the programming host interface and the tile-level ccff_head/ccff_tail pins, in the prog_clk domain.

## Interface
- CHAIN_LEN, 20: number of configuration flip-flops in the chain (≥2).
- WORD_W, 8: host word width (≥2).
- prog_clk  in  1  programming clock; the only clock.
- pReset  in  1  reset, synchronous, active-high.
- start  in  1  begin a pass; sampled only in IDLE or DONE.
- verify  in  1  sampled with start: 0 = PROGRAM, 1 = VERIFY.
- din  in  WORD_W  bitstream word, bit 0 shifted first.
- din_valid  in  1  host word valid.
- din_ready  out  1  controller accepts din this cycle.
- ccff_head  out  1  serial bit into the chain.
- prog_clk_en  out  1  chain shift enable; chain shifts at the prog_clk edge ending a cycle in which it is 1.
- ccff_tail  in  1  last chain FF output.
- busy  out  1  pass in progress.
- done  out  1  pass complete; sticky until next accepted start or reset.
- err  out  1  VERIFY mismatch seen; sticky until next accepted start or reset.
- err_count  out  $clog2(CHAIN_LEN+1)  mismatching bits in last VERIFY pass, saturating at CHAIN_LEN.

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE/DONE --start--> FETCH: clear bit counter, err, err_count, done; latch verify.
- FETCH: din_ready=1; on din_valid load word buffer, bit index 0, -> SHIFT.
- SHIFT: prog_clk_en=1, ccff_head=buffer[bit index]; bit counter and bit index increment each cycle.
  - Bit counter reaches CHAIN_LEN-1 this cycle -> DONE; remaining word bits discarded.
  - Else bit index reaches WORD_W-1 this cycle: din_ready=1; if din_valid, reload buffer and stay in SHIFT (no bubble), else -> FETCH.
- prog_clk_en is 0 in every state except SHIFT; the chain never shifts on a stall.
- VERIFY: in each SHIFT cycle compare ccff_tail with ccff_head; on mismatch set err and increment err_count (saturating). PROGRAM ignores ccff_tail.
- start while busy: ignored. din_valid outside a din_ready cycle: ignored, not consumed.
- pReset mid-pass: next cycle IDLE, all outputs 0; chain contents undefined, no further shifts.

## Timing
- Reset values: din_ready 0, ccff_head 0, prog_clk_en 0, busy 0, done 0, err 0, err_count 0.
- start at cycle t -> FETCH, busy=1, din_ready=1 at t+1.
- Word accepted at cycle f -> first shift at f+1.
- With din_valid held high, a pass takes exactly CHAIN_LEN SHIFT cycles after the first accept: 1 bit/cycle. Total ceil(CHAIN_LEN/WORD_W) words consumed.
- done=1, busy=0 the cycle after the last shift. err/err_count are final in the same cycle.
- All outputs are registered or decoded from state/registers only; none is combinational from din_valid or ccff_tail.

## Structure
- Package ccff_ctrl_pkg: state enum (IDLE, FETCH, SHIFT, DONE), mode constants MODE_PROGRAM=0, MODE_VERIFY=1, counter-width function.
- Sub-module ccff_word_serializer: word buffer, bit index, last_bit flag, reload handshake. Parent keeps FSM, bit counter and compare/error logic.

## Test plan
- PROGRAM, CHAIN_LEN=20, WORD_W=8, words 0xA5, 0x3C, 0x0F, valid always high -> exactly 20 prog_clk_en cycles; head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; done one cycle later; bits 4..7 of 0x0F never driven.
- Same stream, then VERIFY with same words against a behavioural 20-bit chain model -> err=0, err_count=0.
- VERIFY with word 2 changed to 0x0E -> err=1, err_count=1.
- Host drops din_valid for 5 cycles after word 1 -> prog_clk_en low for those 5 cycles, chain model unchanged, final contents identical to the no-stall run.
- pReset asserted at shift 10 -> next cycle IDLE, all outputs 0; new start then completes a full 20-bit pass normally.
- start pulsed during SHIFT and din_valid pulsed in IDLE -> no effect on shift count or word consumption.
